// File: rtl/nes_pad_reader_pkg.sv
// Shared types and constants for the NES pad reader and its consumers.
package pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        DONE
    } pad_state_t;

    localparam int unsigned NUM_BUTTONS = 8;

    // Bit positions in the buttons vector, in controller shift order.
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_pad_reader_if.sv
// Serial controller bus: latch and shift clock out to the pad, data back.
interface nes_pad_reader_if;

    logic pad_latch;
    logic pad_clk;
    logic pad_data;

    modport master (output pad_latch, output pad_clk, input pad_data);
    modport slave  (input pad_latch, input pad_clk, output pad_data);

endinterface

// File: rtl/nes_pad_reader_sync_ff.sv
// Flop-chain synchronizer with a configurable depth and reset level.
module sync_ff #(
    parameter int unsigned DEPTH       = 2,
    parameter logic        RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    // Shift the asynchronous input through the chain; reset to the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {DEPTH{RESET_VALUE}};
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/nes_pad_reader.sv
// Reads an NES serial controller once per frame and presents active-high buttons.
module nes_pad_reader
    import pad_pkg::*;
#(
    parameter int unsigned HALF_CYCLES = 150,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_rate,
    nes_pad_reader_if.master       pad,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic                   button_up,
    output logic                   button_down,
    output logic                   button_left,
    output logic                   button_right,
    output logic                   button_a,
    output logic                   button_b,
    output logic                   scan_valid,
    output logic                   overrun
);

    localparam int unsigned TW = $clog2(2 * HALF_CYCLES);
    localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_CYCLES - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_CYCLES - 1);

    pad_state_t             state, state_next;
    logic [TW-1:0]          timer, timer_next;
    logic [2:0]             idx, idx_next;
    logic [NUM_BUTTONS-1:0] shift, shift_next;
    logic                   sync_data;

    sync_ff #(
        .DEPTH       (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pad.pad_data),
        .q     (sync_data)
    );

    // Next-state, timer, bit index and capture logic for one scan.
    always_comb begin
        state_next = state;
        timer_next = timer + 1'b1;
        idx_next   = idx;
        shift_next = shift;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (frame_rate) begin
                    state_next = LATCH;
                    idx_next   = '0;
                end
            end
            LATCH: begin
                if (timer == LATCH_LAST) begin
                    state_next = CLK_LO;
                    timer_next = '0;
                end
            end
            CLK_LO: begin
                if (timer == HALF_LAST) begin
                    shift_next[idx] = sync_data;
                    timer_next      = '0;
                    state_next      = (idx == 3'd7) ? DONE : CLK_HI;
                end
            end
            CLK_HI: begin
                if (timer == HALF_LAST) begin
                    timer_next = '0;
                    idx_next   = idx + 3'd1;
                    state_next = CLK_LO;
                end
            end
            DONE: begin
                timer_next = '0;
                state_next = IDLE;
            end
            default: begin
                timer_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State registers; pad strobes, valid and buttons are decoded from the next
    // state so they are registered and line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            idx           <= '0;
            shift         <= '1;
            pad.pad_latch <= 1'b0;
            pad.pad_clk   <= 1'b1;
            buttons       <= '0;
            scan_valid    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            idx           <= idx_next;
            shift         <= shift_next;
            pad.pad_latch <= (state_next == LATCH);
            pad.pad_clk   <= (state_next != CLK_LO);
            scan_valid    <= (state_next == DONE);
            if (state_next == DONE) begin
                buttons <= ~shift_next;
            end
            if (frame_rate && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    assign button_up    = buttons[BTN_UP];
    assign button_down  = buttons[BTN_DOWN];
    assign button_left  = buttons[BTN_LEFT];
    assign button_right = buttons[BTN_RIGHT];
    assign button_a     = buttons[BTN_A];
    assign button_b     = buttons[BTN_B];

endmodule
